// File: rtl/sobel_window_buffer.sv
// rtl/sobel_window_buffer.sv - 3x3 sliding window producer for the Sobel gradient blocks
// Optional feature macro: WINDOW_COORD_EN (adds win_row/win_col centre coordinates)
module sobel_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic [0:8][7:0]   window_buffer,
  output logic              start_calculations,
  output logic              frame_done,
  output logic              busy
`ifdef WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [0:8][7:0] win_q, win_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  // Contents are never reset; windows only read them once both rows are refilled.
  logic [7:0]      lb0_mem [IMG_WIDTH];
  logic [7:0]      lb1_mem [IMG_WIDTH];

  logic            accept;
  logic [RW-1:0]   cur_row;
  logic [CW-1:0]   cur_col;
  logic            last_pix;
  logic            win_ok;
  logic [7:0]      pix8;
  logic [7:0]      lb0_rd;
  logic [7:0]      lb1_rd;

`ifdef WINDOW_COORD_EN
  logic [RW-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]   win_col_q, win_col_d;
`endif

  // Decode whether this cycle's pixel is taken and at which coordinate.
  // A frame_start pulse forces the coordinate to (0,0) so a same-cycle pixel starts the new frame.
  always_comb begin
    accept   = pixel_valid && (frame_start || (state_q == S_FILL) || (state_q == S_ACTIVE));
    cur_row  = frame_start ? '0 : row_q;
    cur_col  = frame_start ? '0 : col_q;
    last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    win_ok   = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    pix8     = pixel_in[7:0];
    lb0_rd   = lb0_mem[cur_col];
    lb1_rd   = lb1_mem[cur_col];
  end

  // Next-state logic for the FSM, raster counters, window and strobes.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    win_d   = win_q;
    start_d = 1'b0;
    done_d  = 1'b0;
`ifdef WINDOW_COORD_EN
    win_row_d = win_row_q;
    win_col_d = win_col_q;
`endif

    if (frame_start) begin
      state_d = S_FILL;
      row_d   = '0;
      col_d   = '0;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end

    if (accept) begin
      // Shift left by one column; new right column is {two rows up, one row up, current}.
      win_d = {win_q[1], win_q[2], lb1_rd,
               win_q[4], win_q[5], lb0_rd,
               win_q[7], win_q[8], pix8};

      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end

      start_d = win_ok;
      done_d  = last_pix;

`ifdef WINDOW_COORD_EN
      if (win_ok) begin
        win_row_d = cur_row - 1'b1;
        win_col_d = cur_col - 1'b1;
      end
`endif

      if (last_pix) begin
        state_d = S_DONE;
        row_d   = '0;
        col_d   = '0;
      end else if ((cur_row == ROW_TWO) && (cur_col == '0)) begin
        state_d = S_ACTIVE;
      end
    end

    busy_d = (state_d == S_FILL) || (state_d == S_ACTIVE);
  end

  // State, counters, window and registered outputs; async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      win_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef WINDOW_COORD_EN
      win_row_q <= '0;
      win_col_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef WINDOW_COORD_EN
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
`endif
    end
  end

  // Line buffer update: older row moves to lb1, the new pixel lands in lb0.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[cur_col] <= lb0_rd;
      lb0_mem[cur_col] <= pix8;
    end
  end

  assign window_buffer      = win_q;
  assign start_calculations = start_q;
  assign frame_done         = done_q;
  assign busy               = busy_q;
`ifdef WINDOW_COORD_EN
  assign win_row            = win_row_q;
  assign win_col            = win_col_q;
`endif

endmodule
